// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the shared execute-stage ALU.
// One shift-add (MULTU) or shift-subtract (DIVU) step per cycle, WIDTH steps per operation.
module muldiv_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DZ, S_DONE} state_t;

  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  // ra: acc / rem, rb: mplr / quo, rc: mcand / dvs
  logic [WIDTH-1:0] ra, rb, rc;
  logic [WIDTH-1:0] ra_nx, rb_nx, sh;
  logic             carry, ok;
  logic             last, accept;

  // The ALU has no carry-out; an unsigned add overflowed iff the sum wrapped below an operand.
  function automatic logic add_carry(input logic en, input logic [WIDTH-1:0] sum,
                                     input logic [WIDTH-1:0] addend);
    return en & (sum < addend);
  endfunction

  assign last   = (cnt == LAST);
  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    ra_nx    = ra;
    rb_nx    = rb;
    sh       = {ra[WIDTH-2:0], rb[WIDTH-1]};
    carry    = 1'b0;
    ok       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op)                state_nx = S_MUL;
          else if (rt_val == '0)  state_nx = S_DZ;
          else                    state_nx = S_DIV;
        end
      end
      S_MUL: begin
        alu_a = ra;
        alu_b = rb[0] ? rc : '0;
        carry = add_carry(rb[0], alu_result, ra);
        ra_nx = {carry, alu_result[WIDTH-1:1]};
        rb_nx = {alu_result[0], rb[WIDTH-1:1]};
        if (last) state_nx = S_DONE;
      end
      S_DIV: begin
        alu_a    = sh;
        alu_b    = rc;
        alu_ctrl = ALU_SUB;
        // A set rem MSB means the shifted value exceeds WIDTH bits, so it always covers dvs.
        ok       = ra[WIDTH-1] | (sh >= rc);
        ra_nx    = ok ? alu_result : sh;
        rb_nx    = {rb[WIDTH-2:0], ok};
        if (last) state_nx = S_DONE;
      end
      S_DZ:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_MUL || state == S_DIV) ? cnt + 1'b1 : '0;
      if (accept) div_zero <= 1'b0;
      if ((state == S_MUL || state == S_DIV) && last) begin
        hi <= ra_nx;
        lo <= rb_nx;
      end
      if (state == S_DZ) begin
        hi       <= rb;
        lo       <= '1;
        div_zero <= 1'b1;
      end
    end
  end

  // Working registers; only meaningful while state is MUL/DIV/DZ.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra <= '0;
      rb <= op ? rs_val : rt_val;
      rc <= op ? rt_val : rs_val;
    end else if (state == S_MUL || state == S_DIV) begin
      ra <= ra_nx;
      rb <= rb_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random MULTU/DIVU runs checked
// against plain 64-bit multiply and / % arithmetic, with a behavioural ALU attached.
module tb_muldiv_sequencer;
  localparam int         W   = 32;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic [W-1:0] alu_a, alu_b, alu_result, hi, lo;
  logic [3:0]   alu_ctrl;
  logic         busy, done, div_zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;
  logic         prev_dz = 1'b0;

  always #5 clk = ~clk;

  always_comb alu_result = (alu_ctrl == SUB) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_sequencer #(.WIDTH(W), .ALU_ADD(ADD), .ALU_SUB(SUB)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    logic [63:0] p;
    logic [W-1:0] eh, el;
    logic ez, dz;
    int lat;
    dz = o && (b == '0);
    if (!o) begin
      p = 64'(a) * 64'(b);
      eh = p[63:32]; el = p[31:0]; ez = 1'b0; lat = W + 1;
    end else if (dz) begin
      eh = a; el = '1; ez = 1'b1; lat = 2;
    end else begin
      eh = a % b; el = a / b; ez = 1'b0; lat = W + 1;
    end
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) tick();
      chk("busy", 64'(busy), 64'(1));
      chk("done", 64'(done), 64'(c == lat));
      if (c == 1) chk("div_zero_cleared", 64'(div_zero), 64'(0));
      if (c < lat) begin
        chk("hi_hold", 64'(hi), 64'(prev_hi));
        chk("lo_hold", 64'(lo), 64'(prev_lo));
      end
      if (c < lat && !dz) begin
        chk("alu_ctrl_run", 64'(alu_ctrl), 64'(o ? SUB : ADD));
      end else begin
        chk("alu_ctrl_idle", 64'(alu_ctrl), 64'(ADD));
        chk("alu_a_idle", 64'(alu_a), 64'(0));
        chk("alu_b_idle", 64'(alu_b), 64'(0));
      end
      if (inject && c == 5) begin
        start = 1'b1; op = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
      if (inject && c == 6) start = 1'b0;
      if (inject && c == lat) begin
        start = 1'b1; op = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
    end
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("div_zero", 64'(div_zero), 64'(ez));
    prev_hi = eh; prev_lo = el; prev_dz = ez;
    tick();
    start = 1'b0;
    chk("busy_after", 64'(busy), 64'(0));
    chk("done_after", 64'(done), 64'(0));
    chk("hi_after", 64'(hi), 64'(eh));
    chk("div_zero_held", 64'(div_zero), 64'(ez));
    if (inject) begin
      tick();
      chk("busy_no_restart", 64'(busy), 64'(0));
      chk("done_single", 64'(done), 64'(0));
    end
  endtask

  initial begin
    logic o;
    logic [W-1:0] a, b;
    // Reset state
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div_zero", 64'(div_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(ADD));
    reset = 1'b0;
    tick();

    // Directed cases
    run_op(1'b0, 32'd7, 32'd6, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'd3, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b0, 32'd3, 32'd9, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd3, 32'd10, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op(1'b1, 32'hDEAD_BEEF, 32'd17, 1'b1);

    // Reset in the middle of a DIVU aborts it
    start = 1'b1; op = 1'b1; rs_val = 32'd1000; rt_val = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_alu_ctrl", 64'(alu_ctrl), 64'(ADD));
    reset = 1'b0;
    prev_hi = '0; prev_lo = '0; prev_dz = 1'b0;
    tick();
    chk("abort_no_done", 64'(done), 64'(0));
    run_op(1'b1, 32'd1000, 32'd3, 1'b0);

    // Random runs
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(o, a, b, 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
